// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for a MIPS-style E stage.
// Results are committed to HI/LO only on the final busy edge; MTHI/MTLO write in one cycle.
module md_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] alu_c,
  input  logic [1:0]       rd_sel,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [5:0] MUL_N = 6'(MUL_CYCLES);
  localparam logic [5:0] DIV_N = 6'(DIV_CYCLES);
  localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [0:0]       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic                     is_md;
  logic signed [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0]        prod_u;
  logic [2*WIDTH-1:0]        div_s, div_u;

  // Returns {remainder, quotient}; MOST_NEG / -1 overflow pinned to {0, MOST_NEG}.
  function automatic logic [2*WIDTH-1:0] sdiv(input logic signed [WIDTH-1:0] n,
                                               input logic signed [WIDTH-1:0] d);
    logic signed [WIDTH-1:0] q, r;
    if (d == '0) begin
      q = '0;
      r = '0;
    end else if (n == MOST_NEG && d == '1) begin
      q = MOST_NEG;
      r = '0;
    end else begin
      q = n / d;
      r = n % d;
    end
    return {r, q};
  endfunction

  function automatic logic [2*WIDTH-1:0] udiv(input logic [WIDTH-1:0] n,
                                              input logic [WIDTH-1:0] d);
    if (d == '0) return '0;
    return {n % d, n / d};
  endfunction

  assign prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  assign div_s  = sdiv($signed(a_q), $signed(b_q));
  assign div_u  = udiv(a_q, b_q);

  assign is_md = (op <= OP_DIVU);
  assign busy  = (state_q == ST_BUSY);
  assign stall = busy | (start & is_md);
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_comb begin
    case (rd_sel)
      2'd1:    result = hi_q;
      2'd2:    result = lo_q;
      default: result = alu_c;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == ST_IDLE) begin
      if (start && is_md) begin
        a_d     = a;
        b_d     = b;
        op_d    = op;
        cnt_d   = op[1] ? DIV_N : MUL_N;
        state_d = ST_BUSY;
      end else if (start && op == OP_MTHI) begin
        hi_d = a;
      end else if (start && op == OP_MTLO) begin
        lo_d = a;
      end
    end else begin
      cnt_d = cnt_q - 6'd1;
      // Last busy cycle: commit; a zero divisor leaves HI/LO untouched.
      if (cnt_q == 6'd1) begin
        state_d = ST_IDLE;
        case (op_q)
          OP_MULT:  {hi_d, lo_d} = prod_s;
          OP_MULTU: {hi_d, lo_d} = prod_u;
          OP_DIV:   if (b_q != '0) {hi_d, lo_d} = div_s;
          OP_DIVU:  if (b_q != '0) {hi_d, lo_d} = div_u;
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: default 32-bit instance plus a 16-bit single-cycle-multiply instance.
module tb_md_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b, alu_c;
  logic [1:0]  rd_sel;
  logic [31:0] result, hi, lo;
  logic        busy, stall;

  logic        n_start;
  logic [2:0]  n_op;
  logic [15:0] n_a, n_b, n_alu;
  logic [1:0]  n_rd_sel;
  logic [15:0] n_result, n_hi, n_lo;
  logic        n_busy, n_stall;

  exp_t        sb[$];
  logic [31:0] mdl_hi, mdl_lo;
  int          checks = 0;
  int          errors = 0;

  md_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .alu_c(alu_c),
    .rd_sel(rd_sel), .result(result), .hi(hi), .lo(lo), .busy(busy), .stall(stall)
  );

  md_unit #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(10)) dut16 (
    .clk(clk), .reset(reset), .start(n_start), .op(n_op), .a(n_a), .b(n_b), .alu_c(n_alu),
    .rd_sel(n_rd_sel), .result(n_result), .hi(n_hi), .lo(n_lo), .busy(n_busy), .stall(n_stall)
  );

  always #5 clk = ~clk;

  // Reference model built from magnitudes so signed rules are derived independently.
  function automatic void model(input logic [2:0] o, input logic [31:0] va, vb,
                                input logic [31:0] hin, lin,
                                output logic [31:0] hout, lout);
    logic [63:0] p;
    logic [31:0] ua, ub, q, r;
    hout = hin;
    lout = lin;
    case (o)
      3'd0: begin
        p = 64'(longint'(signed'(va)) * longint'(signed'(vb)));
        {hout, lout} = p;
      end
      3'd1: begin
        p = {32'd0, va} * {32'd0, vb};
        {hout, lout} = p;
      end
      3'd2: if (vb != 0) begin
        ua = va[31] ? -va : va;
        ub = vb[31] ? -vb : vb;
        q = ua / ub;
        r = ua % ub;
        if (va[31] != vb[31]) q = -q;
        if (va[31]) r = -r;
        lout = q;
        hout = r;
      end
      3'd3: if (vb != 0) begin
        lout = va / vb;
        hout = va % vb;
      end
      default: ;
    endcase
  endfunction

  task automatic wait_done(input string name);
    exp_t e;
    int   n = 0;
    bit   early = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (hi !== mdl_hi || lo !== mdl_lo) early = 1;
      @(negedge clk);
    end
    e = sb.pop_front();
    checks++;
    if (n !== e.cyc) begin errors++; $display("FAIL %s busy_cycles got %0d want %0d", name, n, e.cyc); end
    checks++;
    if (early) begin errors++; $display("FAIL %s early_visibility got 1 want 0", name); end
    checks++;
    if (hi !== e.hi || lo !== e.lo) begin
      errors++; $display("FAIL %s hilo got %h_%h want %h_%h", name, hi, lo, e.hi, e.lo);
    end
    mdl_hi = e.hi;
    mdl_lo = e.lo;
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] va, vb);
    exp_t e;
    model(o, va, vb, mdl_hi, mdl_lo, e.hi, e.lo);
    e.cyc = o[1] ? 10 : 5;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL %s stall_issue got %b want 1", name, stall); end
    @(negedge clk);
    start = 1'b0;
    wait_done(name);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL reset got hi=%h lo=%h busy=%b stall=%b want 0", hi, lo, busy, stall);
    end
    alu_c = 32'hA5A5_0001;
    #1;
    checks++;
    if (result !== 32'hA5A5_0001) begin errors++; $display("FAIL reset_result got %h want a5a50001", result); end
    mdl_hi = 32'd0;
    mdl_lo = 32'd0;
  endtask

  task automatic test_mult();
    run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      errors++; $display("FAIL mult_const got %h_%h want ffffffff_fffffffa", hi, lo);
    end
    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      errors++; $display("FAIL multu_const got %h_%h want fffffffe_00000001", hi, lo);
    end
  endtask

  task automatic test_div();
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_const got hi=%h lo=%h want ffffffff fffffffd", hi, lo);
    end
    run_op("div_zero", 3'd2, 32'd1234, 32'd0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_negdivisor", 3'd2, 32'd7, 32'hFFFF_FFFE);
    run_op("divu", 3'd3, 32'hF000_0000, 32'd7);
    run_op("divu_zero", 3'd3, 32'd99, 32'd0);
  endtask

  task automatic test_mt();
    exp_t e;
    e.hi = 32'h1234_5678; e.lo = mdl_lo; e.cyc = 0;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h1234_5678;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL mthi_stall got %b want 0", stall); end
    @(negedge clk);
    start = 1'b0; rd_sel = 2'd1;
    #1;
    e = sb.pop_front();
    checks++;
    if (result !== e.hi || busy !== 1'b0) begin
      errors++; $display("FAIL mthi_result got %h busy=%b want %h busy=0", result, busy, e.hi);
    end
    mdl_hi = e.hi;
    e.hi = mdl_hi; e.lo = 32'hCAFE_F00D; e.cyc = 0;
    sb.push_back(e);
    start = 1'b1; op = 3'd5; a = 32'hCAFE_F00D;
    @(negedge clk);
    start = 1'b0; rd_sel = 2'd2;
    #1;
    e = sb.pop_front();
    checks++;
    if (result !== e.lo || hi !== e.hi) begin
      errors++; $display("FAIL mtlo_result got %h hi=%h want %h hi=%h", result, hi, e.lo, e.hi);
    end
    mdl_lo = e.lo;
    rd_sel = 2'd3; alu_c = 32'h0BAD_BEEF;
    #1;
    checks++;
    if (result !== 32'h0BAD_BEEF) begin errors++; $display("FAIL rdsel3 got %h want 0badbeef", result); end
    rd_sel = 2'd0;
  endtask

  task automatic test_ignored_op();
    @(negedge clk);
    start = 1'b1; op = 3'd6; a = 32'hDEAD_0000;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL op6_stall got %b want 0", stall); end
    @(negedge clk);
    op = 3'd7;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== mdl_hi || lo !== mdl_lo) begin
      errors++; $display("FAIL op67_ignored got busy=%b %h_%h want 0 %h_%h", busy, hi, lo, mdl_hi, mdl_lo);
    end
  endtask

  task automatic test_busy_ignore();
    exp_t e;
    int   n = 0;
    model(3'd3, 32'd100, 32'd7, mdl_hi, mdl_lo, e.hi, e.lo);
    e.cyc = 10;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'h7FFF_FFFF; b = 32'd9;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL busy_stall got %b want 1", stall); end
    @(negedge clk);
    start = 1'b1; op = 3'd4;
    @(negedge clk);
    start = 1'b0;
    n = 4;
    while (busy === 1'b1 && n < 200) begin n++; @(negedge clk); end
    e = sb.pop_front();
    checks++;
    if (n !== e.cyc || hi !== e.hi || lo !== e.lo) begin
      errors++; $display("FAIL busy_ignore got cyc=%0d %h_%h want cyc=%0d %h_%h", n, hi, lo, e.cyc, e.hi, e.lo);
    end
    mdl_hi = e.hi;
    mdl_lo = e.lo;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_prebusy got %b want 1", busy); end
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL abort got busy=%b %h_%h want 0 0_0", busy, hi, lo);
    end
    mdl_hi = 32'd0;
    mdl_lo = 32'd0;
    repeat (12) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL abort_nowrite got busy=%b %h_%h want 0 0_0", busy, hi, lo);
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] va, vb;
    for (int i = 0; i < 8; i++) begin
      o  = 3'($urandom_range(0, 3));
      va = $urandom;
      vb = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
      if (i == 5) vb = 32'hFFFF_FFFF;
      run_op("random", o, va, vb);
    end
  endtask

  task automatic test_width16();
    exp_t e;
    int   n = 0;
    e.hi = 32'h0000_FFFF; e.lo = 32'h0000_FFFA; e.cyc = 1;
    sb.push_back(e);
    @(negedge clk);
    n_start = 1'b1; n_op = 3'd0; n_a = 16'hFFFE; n_b = 16'd3;
    @(negedge clk);
    n_start = 1'b0;
    while (n_busy === 1'b1 && n < 50) begin n++; @(negedge clk); end
    e = sb.pop_front();
    checks++;
    if (n !== e.cyc || {16'd0, n_hi} !== e.hi || {16'd0, n_lo} !== e.lo) begin
      errors++; $display("FAIL w16_mult got cyc=%0d %h_%h want cyc=%0d %h_%h", n, n_hi, n_lo, e.cyc, e.hi[15:0], e.lo[15:0]);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; alu_c = '0; rd_sel = 2'd0;
    n_start = 1'b0; n_op = 3'd0; n_a = '0; n_b = '0; n_alu = '0; n_rd_sel = 2'd0;
    mdl_hi = '0; mdl_lo = '0;
    test_reset();
    test_mult();
    test_div();
    test_mt();
    test_ignored_op();
    test_busy_ignore();
    test_random();
    test_back_to_back();
    test_width16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
